alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one WIDTH-bit ALU between two requesters: requester 0 is the execute stage, requester 1 is the
//  address/branch unit. Round-robin arbitration, valid/ready on each input. Registered response with
//  ALU flags (negative, zero, overflow, carry) and a requester ID. Sits between decode/issue and the
//  flag/writeback logic of the pipelined CPU.
// PARAMETERS
//  WIDTH  64  operand/result width; flags derive from result[WIDTH-1:0]
// PORTS
//  clk           in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-high
//  req0_valid    in   1      requester 0 holds a valid operation
//  req0_ready    out  1      requester 0 operation accepted this cycle
//  req0_op       in   3      alu_op_e opcode
//  req0_a        in   WIDTH  operand A
//  req0_b        in   WIDTH  operand B
//  req1_valid/req1_ready/req1_op/req1_a/req1_b   same as requester 0, for requester 1
//  rsp_valid     out  1      response register holds a result
//  rsp_ready     in   1      consumer takes the response this cycle
//  rsp_id        out  1      requester that issued the held result
//  rsp_result    out  WIDTH  ALU result
//  rsp_negative  out  1      rsp_result[WIDTH-1]
//  rsp_zero      out  1      rsp_result == 0
//  rsp_overflow  out  1      signed overflow (ADD/SUB only, else 0)
//  rsp_carry     out  1      carry out, no-borrow for SUB (ADD/SUB only, else 0)
// BEHAVIOUR
//  Reset: rsp_valid=0; rsp_id, rsp_result and all flags =0; rr_ptr=0 (requester 0 has priority).
//  Reset overrides everything and drops any held response.
//  Ops: 000 ADD a+b; 001 SUB a-b (a+~b+1); 010 AND; 011 OR; 100 XOR; 101 PASS_B.
//  Ops 110/111 are illegal: result=0, zero=1, other flags 0. The response is still returned.
//  slot_free = !rsp_valid || rsp_ready (a held response drains in the same cycle a new op is accepted).
//  Grant (combinational, at most one):
//   - Nothing is granted unless slot_free.
//   - If only one reqN_valid is high, grant N.
//   - If both are high, grant rr_ptr.
//  reqN_ready = grant[N]. Ready depends on valid; a requester must not wait on ready before raising valid.
//  On a grant: next cycle rsp_valid=1 and rsp_* = ALU(granted op); rr_ptr <= ~granted ID.
//  Latency is exactly 1 cycle from accept to rsp_valid.
//  If there is no grant and rsp_ready=1: rsp_valid <= 0, data registers keep their values.
//  If there is no grant and rsp_ready=0: all rsp_* hold and stay stable while rsp_valid && !rsp_ready.
//  Back-to-back: 1 result per cycle while rsp_ready=1. Both requesters valid gives strict alternation.
//  rr_ptr changes only on a grant. A lone requester never loses its turn to an idle one.
//  State: response register is EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
//   EMPTY --grant--> FULL
//   FULL --rsp_ready & !grant--> EMPTY
//   FULL --rsp_ready & grant--> FULL, new data
//   FULL --!rsp_ready--> FULL, hold
//  Carry/overflow use a WIDTH+1 bit sum. overflow = (a[msb]==b'[msb]) && (sum[msb]!=a[msb]),
//  where b' = b for ADD and ~b for SUB.
//  Inputs are sampled only when granted. Operand changes while ready=0 are legal and ignored.
// STRUCTURE
//  alu_pkg (shared package): typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
//   ALU_XOR, ALU_PASSB}; localparam ALU_OP_W=3.
//  Sub-module alu_core #(WIDTH): purely combinational (op, a, b) -> (result, negative, zero,
//   overflow, carry). The arbiter instantiates one alu_core on the muxed granted operands.
//  Arbiter, round-robin pointer and response register live in this module.
// TESTING
//  1. reset=1 for 2 cycles, req0_valid=1 -> req0_ready=0 during reset; rsp_valid=0, rsp_result=0.
//  2. req0 only, XOR a=64'hFFFF_0000_FFFF_0000, b=64'hFFFF_0000_FFFF_0000, rsp_ready=1
//     -> next cycle rsp_valid=1, id=0, result=0, zero=1, negative=0.
//  3. Both valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1. Then req1 ADD 64'h7FFF..FF + 1
//     -> result=64'h8000..00, negative=1, overflow=1, carry=0.
//  4. Response held with rsp_ready=0 for 3 cycles while both requesters valid -> both ready=0;
//     rsp_* unchanged. rsp_ready=1 -> same-cycle grant, new result next cycle.
//  5. SUB a=5 b=5 -> result=0, zero=1, carry=1. Illegal op 3'b111 -> result=0, zero=1, overflow=0, carry=0.
//  6. reset asserted while rsp_valid=1, rsp_ready=0 -> next cycle rsp_valid=0, rr_ptr=0;
//     both valid after release -> req0 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode definitions
package alu_pkg;

    localparam int ALU_OP_W = 3;

    // Encodings 110/111 are deliberately unnamed: they are the illegal opcodes.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_PASSB = 3'd5
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU with negative/zero/overflow/carry flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_negative,
    output logic                o_zero,
    output logic                o_overflow,
    output logic                o_carry
);

    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // SUB reuses the adder as a + ~b + 1, so carry means "no borrow".
    assign w_is_sub = (i_op == ALU_SUB);
    assign w_b_eff  = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_carry    = 1'b0;
        case (i_op)
            ALU_ADD, ALU_SUB: begin
                o_result   = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

    assign o_negative = o_result[WIDTH-1];
    assign o_zero     = (o_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_negative,
    output logic                rsp_zero,
    output logic                rsp_overflow,
    output logic                rsp_carry
);

    logic                w_slot_free;
    logic                w_grant0;
    logic                w_grant1;
    logic [ALU_OP_W-1:0] w_op;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [WIDTH-1:0]    w_result;
    logic                w_negative;
    logic                w_zero;
    logic                w_overflow;
    logic                w_carry;

    logic                r_rr_ptr;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [WIDTH-1:0]    r_rsp_result;
    logic                r_rsp_negative;
    logic                r_rsp_zero;
    logic                r_rsp_overflow;
    logic                r_rsp_carry;

    // A held response drains in the same cycle a new op is accepted.
    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign w_grant0    = !reset && w_slot_free && req0_valid && (!req1_valid || !r_rr_ptr);
    assign w_grant1    = !reset && w_slot_free && req1_valid && (!req0_valid ||  r_rr_ptr);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_op = w_grant1 ? req1_op : req0_op;
    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .i_op       (w_op),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_result   (w_result),
        .o_negative (w_negative),
        .o_zero     (w_zero),
        .o_overflow (w_overflow),
        .o_carry    (w_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr       <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_negative <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_carry    <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            // Pointer moves to the requester that was not just served.
            r_rr_ptr       <= !w_grant1;
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= w_grant1;
            r_rsp_result   <= w_result;
            r_rsp_negative <= w_negative;
            r_rsp_zero     <= w_zero;
            r_rsp_overflow <= w_overflow;
            r_rsp_carry    <= w_carry;
        end else if (rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_negative = r_rsp_negative;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_carry    = r_rsp_carry;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_negative, rsp_zero, rsp_overflow, rsp_carry;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state: what the response register and turn pointer should hold.
    logic        m_valid, m_id, m_ptr;
    logic [63:0] m_res;
    logic [3:0]  m_flg;
    logic        last_r0, last_r1;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  flg;
    } vec_t;
    vec_t vt[12];

    alu_share_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry)
    );

    always #5 clk = ~clk;

    // Returns {result, negative, zero, overflow, carry} from plain arithmetic.
    function automatic logic [67:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [64:0]        u;
        logic signed [64:0] s;
        logic [63:0]        r;
        logic               v, c;
        r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin
                u = {1'b0, a} + {1'b0, b};
                r = u[63:0];
                c = u[64];
                s = $signed({a[63], a}) + $signed({b[63], b});
                v = s[64] ^ s[63];
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = $signed({a[63], a}) - $signed({b[63], b});
                v = s[64] ^ s[63];
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            default: r = '0;
        endcase
        return {r, r[63], (r == 64'd0), v, c};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'(unsigned'($urandom_range(0, 3)));
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // One clock: check readies before the edge, advance the model, check the response after.
    task automatic cycle(input string tag);
        logic       free, g0, g1;
        logic [67:0] alu;
        #1;
        free = !m_valid || rsp_ready;
        if (reset || !free)                   begin g0 = 0; g1 = 0; end
        else if (req0_valid && req1_valid)    begin g0 = !m_ptr; g1 = m_ptr; end
        else                                  begin g0 = req0_valid; g1 = req1_valid; end
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        chk({tag, "_ready"}, {62'd0, req1_ready, req0_ready}, {62'd0, g1, g0});
        if (reset) alu = '0;
        else if (g1) alu = ref_alu(req1_op, req1_a, req1_b);
        else alu = ref_alu(req0_op, req0_a, req0_b);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_id = 0; m_ptr = 0; m_res = '0; m_flg = '0;
        end else if (g0 || g1) begin
            m_valid = 1; m_id = g1; m_ptr = !g1; m_res = alu[67:4]; m_flg = alu[3:0];
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
        chk({tag, "_vld_id"}, {62'd0, rsp_valid, rsp_id}, {62'd0, m_valid, m_id});
        chk({tag, "_result"}, rsp_result, m_res);
        chk({tag, "_flags"}, {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry}, {60'd0, m_flg});
    endtask

    task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    logic [63:0] held_res;

    initial begin
        vt[0]  = '{3'd4, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 64'h0, 4'b0100};
        vt[1]  = '{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1010};
        vt[2]  = '{3'd1, 64'd5, 64'd5, 64'h0, 4'b0101};
        vt[3]  = '{3'd7, 64'd123, 64'd456, 64'h0, 4'b0100};
        vt[4]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0100};
        vt[5]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0101};
        vt[6]  = '{3'd1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        vt[7]  = '{3'd1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vt[8]  = '{3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0_00F0, 4'b0000};
        vt[9]  = '{3'd3, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0001, 4'b1000};
        vt[10] = '{3'd5, 64'hDEAD, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 4'b0000};
        vt[11] = '{3'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b0111};

        m_valid = 0; m_id = 0; m_ptr = 0; m_res = '0; m_flg = '0;
        reset = 1; rsp_ready = 1;
        set_req(0, 1, 3'd0, 64'd1, 64'd2);
        set_req(1, 0, 3'd0, 64'd0, 64'd0);

        // Reset with a pending request: never ready, response cleared.
        for (int i = 0; i < 2; i++) cycle("reset");
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        reset = 0;
        set_req(0, 0, 3'd0, 64'd0, 64'd0);
        cycle("idle");

        // Table vectors, alternating the issuing requester.
        for (int i = 0; i < 12; i++) begin
            set_req(i % 2, 1, vt[i].op, vt[i].a, vt[i].b);
            cycle("vec");
            chk($sformatf("vec%0d_result", i), rsp_result, vt[i].res);
            chk($sformatf("vec%0d_flags", i), {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry}, {60'd0, vt[i].flg});
            chk($sformatf("vec%0d_id", i), {63'd0, rsp_id}, 64'(i % 2));
            set_req(i % 2, 0, 3'd0, 64'd0, 64'd0);
        end

        // Both valid: strict alternation 0,1,0,1.
        set_req(0, 1, 3'd3, 64'h10, 64'h01);
        set_req(1, 1, 3'd2, 64'hFF, 64'h0F);
        for (int i = 0; i < 4; i++) begin
            cycle("alt");
            chk($sformatf("alt%0d_id", i), {63'd0, rsp_id}, 64'(i % 2));
        end
        set_req(0, 0, 3'd0, 64'd0, 64'd0);
        set_req(1, 1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        cycle("ovf");
        chk("ovf_flags", {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry}, 64'b1010);

        // Held response with both valid: no grants, outputs frozen.
        held_res = 64'h8000_0000_0000_0000;
        rsp_ready = 0;
        set_req(0, 1, 3'd1, 64'd9, 64'd4);
        set_req(1, 1, 3'd4, 64'hAA, 64'h55);
        for (int i = 0; i < 3; i++) begin
            cycle("hold");
            chk("hold_ready", {62'd0, last_r1, last_r0}, 64'd0);
            chk("hold_result", rsp_result, held_res);
            req0_a = req0_a + 64'd1;
        end
        rsp_ready = 1;
        cycle("drain");
        chk("drain_same_cycle_grant", {62'd0, last_r1, last_r0}, 64'b01);
        chk("drain_new_result", rsp_result, 64'd8);

        // Reset while a response is held and the pointer favours requester 1.
        rsp_ready = 0;
        set_req(1, 0, 3'd0, 64'd0, 64'd0);
        set_req(0, 0, 3'd0, 64'd0, 64'd0);
        cycle("pre_rst");
        reset = 1;
        cycle("mid_rst");
        chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        reset = 0;
        rsp_ready = 1;
        set_req(0, 1, 3'd5, 64'd0, 64'h55);
        set_req(1, 1, 3'd5, 64'd0, 64'h66);
        cycle("post_rst");
        chk("post_rst_first_id", {63'd0, rsp_id}, 64'd0);
        chk("post_rst_first_res", rsp_result, 64'h55);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            set_req(0, $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), rnd64(), rnd64());
            set_req(1, $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), rnd64(), rnd64());
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
